// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, reset constants and the configuration record used
// for both the pending and the shadow (active) register sets of pwm_gen.
package pwm_pkg;

    localparam int CNT_W   = 8;
    localparam int PRESC_W = 4;
    localparam int DEAD_W  = 4;

    localparam logic [CNT_W-1:0] PWM_RST_PERIOD = '1;
    localparam logic [CNT_W-1:0] PWM_RST_DUTY   = '0;

    typedef struct packed {
        logic               en;
        logic [PRESC_W-1:0] prescale;
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   duty;
        logic [DEAD_W-1:0]  dead;
    } pwm_cfg_t;

    localparam pwm_cfg_t PWM_CFG_RST = '{
        en:       1'b0,
        prescale: '0,
        period:   PWM_RST_PERIOD,
        duty:     PWM_RST_DUTY,
        dead:     '0
    };

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: splits the registered raw PWM into a high-side / low-side
// pair with a programmable both-low gap after every raw transition.
// Outputs are decoded from registers only, so with dead_i = 0 both sides
// carry the same latency as the raw signal.
module pwm_deadtime #(
    parameter int DEAD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              raw_i,
    input  logic [DEAD_W-1:0] dead_i,
    output logic              pwm_o,
    output logic              pwm_n_o
);

    logic              raw_prev_q;
    logic [DEAD_W-1:0] elap_q, elap_d;
    logic [DEAD_W-1:0] elapsed;
    logic              gap_done;

    // Cycles since the last raw edge, saturating once the gap is satisfied.
    always_comb begin
        elapsed  = (raw_i != raw_prev_q) ? '0 : elap_q;
        gap_done = (elapsed >= dead_i);
        elap_d   = gap_done ? elapsed : elapsed + DEAD_W'(1);
        pwm_o    = en_i && raw_i && gap_done;
        pwm_n_o  = en_i && !raw_i && gap_done;
    end

    // Edge-detect history and gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_prev_q <= 1'b0;
            elap_q     <= '0;
        end else begin
            raw_prev_q <= raw_i;
            elap_q     <= elap_d;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: double-buffered PWM generator. Writes land in a pending set and
// move to the active set only at a period boundary (or immediately while
// disabled), so a running waveform never glitches mid-period.
// Optional macro PWM_DEADTIME_EN adds cfg_dead / pwm_n_o and a complementary
// output pair with dead time. The width parameters must equal the pwm_pkg
// defaults because the configuration record is sized from the package.
module pwm_gen #(
    parameter int CNT_W   = pwm_pkg::CNT_W,
    parameter int PRESC_W = pwm_pkg::PRESC_W,
    parameter int DEAD_W  = pwm_pkg::DEAD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_en,
    input  logic [PRESC_W-1:0] cfg_prescale,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_duty,
`ifdef PWM_DEADTIME_EN
    input  logic [DEAD_W-1:0]  cfg_dead,
    output logic               pwm_n_o,
`endif
    input  logic               cfg_wr,
    output logic               pwm_o,
    output logic               cycle_end_o,
    output logic               upd_pend_o
);

    import pwm_pkg::*;

    pwm_cfg_t           pend_q, pend_d;
    pwm_cfg_t           shad_q, shad_d;
    logic               upd_pend_q, upd_pend_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pwm_raw_q, pwm_raw_d;
    logic               tick, wrap, load;

    assign tick = shad_q.en && (presc_cnt_q == shad_q.prescale);
    assign wrap = tick && (cnt_q == shad_q.period);
    // While running, only a period boundary may change the active set.
    assign load = upd_pend_q && (!shad_q.en || wrap);

    // Next-state: config buffering, prescaler, period counter, raw output.
    always_comb begin
        pend_d      = pend_q;
        shad_d      = shad_q;
        upd_pend_d  = upd_pend_q;
        presc_cnt_d = presc_cnt_q;
        cnt_d       = cnt_q;

        // Load takes the old pending values; a coincident write refills pending.
        if (load) begin
            shad_d     = pend_q;
            upd_pend_d = 1'b0;
        end
        if (cfg_wr) begin
            pend_d.en       = cfg_en;
            pend_d.prescale = cfg_prescale;
            pend_d.period   = cfg_period;
            pend_d.duty     = cfg_duty;
`ifdef PWM_DEADTIME_EN
            pend_d.dead     = cfg_dead;
`else
            pend_d.dead     = '0;
`endif
            upd_pend_d      = 1'b1;
        end

        if (!shad_q.en) begin
            presc_cnt_d = '0;
            cnt_d       = '0;
        end else if (tick) begin
            presc_cnt_d = '0;
            cnt_d       = wrap ? '0 : cnt_q + CNT_W'(1);
        end else begin
            presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        end

        pwm_raw_d = shad_q.en && (cnt_q < shad_q.duty);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= PWM_CFG_RST;
            shad_q      <= PWM_CFG_RST;
            upd_pend_q  <= 1'b0;
            presc_cnt_q <= '0;
            cnt_q       <= '0;
            pwm_raw_q   <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            shad_q      <= shad_d;
            upd_pend_q  <= upd_pend_d;
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
            pwm_raw_q   <= pwm_raw_d;
        end
    end

    assign cycle_end_o = wrap;
    assign upd_pend_o  = upd_pend_q;

`ifdef PWM_DEADTIME_EN
    logic en_dly_q;

    // Enable delayed by one clk so it lines up with the registered raw PWM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_dly_q <= 1'b0;
        else        en_dly_q <= shad_q.en;
    end

    pwm_deadtime #(
        .DEAD_W (DEAD_W)
    ) u_deadtime (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en_dly_q),
        .raw_i   (pwm_raw_q),
        .dead_i  (shad_q.dead),
        .pwm_o   (pwm_o),
        .pwm_n_o (pwm_n_o)
    );
`else
    logic [DEAD_W-1:0] unused_dead;
    assign unused_dead = shad_q.dead;
    assign pwm_o       = pwm_raw_q;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed bench for pwm_gen with hand-derived waveforms.
module tb_pwm_gen;

    logic       clk;
    logic       rst_n;
    logic       cfg_en;
    logic [3:0] cfg_prescale;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic       cfg_wr;
    logic       pwm_o;
    logic       cycle_end_o;
    logic       upd_pend_o;
`ifdef PWM_DEADTIME_EN
    logic [3:0] cfg_dead;
    logic       pwm_n_o;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    pwm_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_en       (cfg_en),
        .cfg_prescale (cfg_prescale),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
`ifdef PWM_DEADTIME_EN
        .cfg_dead     (cfg_dead),
        .pwm_n_o      (pwm_n_o),
`endif
        .cfg_wr       (cfg_wr),
        .pwm_o        (pwm_o),
        .cycle_end_o  (cycle_end_o),
        .upd_pend_o   (upd_pend_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        cfg_en       = 1'b0;
        cfg_prescale = '0;
        cfg_period   = '0;
        cfg_duty     = '0;
        cfg_wr       = 1'b0;
`ifdef PWM_DEADTIME_EN
        cfg_dead     = '0;
`endif
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wr(input logic en, input int presc, input int per, input int duty, input int dead);
        cfg_en       = en;
        cfg_prescale = 4'(presc);
        cfg_period   = 8'(per);
        cfg_duty     = 8'(duty);
`ifdef PWM_DEADTIME_EN
        cfg_dead     = 4'(dead);
`else
        if (dead != 0) $display("note: dead-time value ignored in this build");
`endif
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
    endtask

    // Write while disabled, step to s=0 (first clk with shadow enabled),
    // then compare samples s=1..n against a period of per clks with hi clks high.
    task automatic run_wave(input string tag, input int presc, input int per_cnt, input int duty,
                            input int per, input int hi, input int n);
        int x;
        wr(1'b1, presc, per_cnt, duty, 0);
        chk({tag, "_pend"}, upd_pend_o, 1);
        step();
        chk({tag, "_pend_clr"}, upd_pend_o, 0);
        for (int s = 1; s <= n; s++) begin
            step();
            x = (s + per - 1) % per;
            chk({tag, "_pwm"}, pwm_o, (x < hi) ? 1 : 0);
            chk({tag, "_ce"}, cycle_end_o, ((s % per) == per - 1) ? 1 : 0);
        end
    endtask

    initial begin
        int hi_pwm, hi_ce, hi_up;
        int cnt_a, cnt_b;
        logic pw[0:20];

        // Reset defaults held for 1000 clks with no writes.
        do_reset();
        hi_pwm = 0; hi_ce = 0; hi_up = 0;
        for (int i = 0; i < 1000; i++) begin
            if (pwm_o) hi_pwm++;
            if (cycle_end_o) hi_ce++;
            if (upd_pend_o) hi_up++;
            step();
        end
        chk("rst_pwm_high_cnt", hi_pwm, 0);
        chk("rst_ce_high_cnt", hi_ce, 0);
        chk("rst_pend_high_cnt", hi_up, 0);

        // Basic: 3 high / 7 low, cycle_end every 10 clks.
        run_wave("basic", 0, 9, 3, 10, 3, 40);

        // Prescale 3, period 4, duty 2: 20 clk period, 8 high.
        do_reset();
        run_wave("presc", 3, 4, 2, 20, 8, 60);

        // Duty 0: never high.
        do_reset();
        run_wave("duty0", 0, 9, 0, 10, 0, 30);

        // Duty above period: constantly high.
        do_reset();
        run_wave("duty_gt", 0, 9, 12, 10, 10, 30);

        // Duty equal to period: low for one tick.
        do_reset();
        run_wave("duty_eq", 0, 9, 9, 10, 9, 30);

        // Period 0, duty 1: constantly high, cycle_end every tick.
        do_reset();
        run_wave("per0", 0, 0, 1, 1, 1, 20);

        // Glitch-free update: duty 3 -> 7 written while cnt == 1.
        do_reset();
        wr(1'b1, 0, 9, 3, 0);
        step();
        pw[0] = pwm_o;
        step();
        pw[1] = pwm_o;
        wr(1'b1, 0, 9, 7, 0);
        pw[2] = pwm_o;
        chk("upd_pend_set", upd_pend_o, 1);
        for (int s = 3; s <= 20; s++) begin
            step();
            pw[s] = pwm_o;
            if (s == 9) begin
                chk("upd_hold_at_ce", upd_pend_o, 1);
                chk("ce_at_wrap", cycle_end_o, 1);
            end
            if (s == 10) chk("upd_clr_after_ce", upd_pend_o, 0);
        end
        cnt_a = 0; cnt_b = 0;
        for (int s = 1; s <= 10; s++) if (pw[s]) cnt_a++;
        for (int s = 11; s <= 20; s++) if (pw[s]) cnt_b++;
        chk("upd_cur_period_high", cnt_a, 3);
        chk("upd_next_period_high", cnt_b, 7);
        chk("upd_first_low", pw[4], 0);
        chk("upd_next_last_high", pw[17], 1);

        // Async reset in the middle of a high phase.
        do_reset();
        wr(1'b1, 0, 9, 3, 0);
        step();
        step();
        step();
        chk("pre_rst_pwm", pwm_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", pwm_o, 0);
        chk("async_rst_pend", upd_pend_o, 0);
        chk("async_rst_ce", cycle_end_o, 0);
        #2;
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_pwm", pwm_o, 0);

`ifdef PWM_DEADTIME_EN
        // Dead time 2, period 9, duty 5: 3 high each side, 2-clk gaps.
        do_reset();
        wr(1'b1, 0, 9, 5, 2);
        step();
        cnt_a = 0;
        for (int s = 1; s <= 40; s++) begin
            int x;
            step();
            x = (s - 1) % 10;
            chk("dt_pwm", pwm_o, (x >= 2 && x <= 4) ? 1 : 0);
            chk("dt_pwm_n", pwm_n_o, (x >= 7) ? 1 : 0);
            if (pwm_o && pwm_n_o) cnt_a++;
        end
        chk("dt_overlap_cnt", cnt_a, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
